// File: rtl/plcp_pkg.sv
// Shared definitions for the 802.11a PLCP transmitter: state encoding, field lengths,
// RATE codes and the data-bits-per-symbol lookup.
package plcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SIGNAL,
        ST_SERVICE,
        ST_PSDU,
        ST_TAIL,
        ST_PAD
    } plcp_state_e;

    localparam int PREAMBLE_BITS = 96;
    localparam int SIGNAL_BITS   = 24;
    localparam int SERVICE_BITS  = 16;
    localparam int TAIL_BITS     = 6;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    function automatic logic rate_is_valid(input logic [3:0] rate);
        case (rate)
            RATE_6M, RATE_9M, RATE_12M, RATE_18M,
            RATE_24M, RATE_36M, RATE_48M, RATE_54M: rate_is_valid = 1'b1;
            default:                                rate_is_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] n_dbps(input logic [3:0] rate);
        case (rate)
            RATE_6M:  n_dbps = 8'd24;
            RATE_9M:  n_dbps = 8'd36;
            RATE_12M: n_dbps = 8'd48;
            RATE_18M: n_dbps = 8'd72;
            RATE_24M: n_dbps = 8'd96;
            RATE_36M: n_dbps = 8'd144;
            RATE_48M: n_dbps = 8'd192;
            RATE_54M: n_dbps = 8'd216;
            default:  n_dbps = 8'd24;
        endcase
    endfunction

endpackage

// File: rtl/plcp_transmitter_scrambler.sv
// 7-bit x^7+x^4+1 scrambler: synchronous load of the seed, per-bit advance, combinational bit-in/bit-out.
module tx_scrambler #(
    parameter logic [6:0] SEED = 7'b1111111
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    input  logic bit_in,
    output logic bit_out
);

    logic [7:1] lfsr_q;
    logic [7:1] lfsr_d;
    logic       feedback;

    always_comb begin
        feedback = lfsr_q[7] ^ lfsr_q[4];
        bit_out  = bit_in ^ feedback;
        lfsr_d   = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (enable) begin
            lfsr_d = {lfsr_q[6:1], feedback};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/plcp_transmitter.sv
// Serial 802.11a PLCP frame builder: PREAMBLE, SIGNAL, SERVICE, PSDU, TAIL and, when
// TX_PAD_EN is defined, PAD up to a whole OFDM symbol. One bit per clock.
module plcp_transmitter
    import plcp_pkg::*;
#(
    parameter logic [6:0] SCRAMBLER_SEED = 7'b1111111,
    parameter logic [7:0] PREAMBLE_BYTE  = 8'hAA
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Rate,
    input  logic [11:0] Length,
    input  logic [7:0]  Data_in,
    input  logic        Data_valid,
    output logic        Data_ready,
    output logic        Tx_bit,
    output logic        Tx_valid,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    plcp_state_e state_q, state_d;
    logic [14:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]  rate_q, rate_d;
    logic [11:0] len_q, len_d;
    logic [11:0] bytes_left_q, bytes_left_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  cur_q, cur_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
`ifdef TX_PAD_EN
    logic [7:0]  sym_q, sym_d;
    logic [7:0]  sym_last;
`endif

    logic        data_ready;
    logic        byte_xfer;
    logic        byte_start;
    logic        psdu_bit;
    logic        scr_in;
    logic        scr_out;
    logic        scr_load;
    logic        scr_en;
    logic        tx_bit;
    logic        tx_valid;
    logic        underrun;
    logic [23:0] signal_word;
    logic [14:0] psdu_last;

    // Byte handshake: a byte moves into the one-byte buffer on the cycle where
    // Data_valid and Data_ready are both high; Data_ready never depends on Data_valid.
    assign data_ready = ((state_q == ST_SERVICE) || (state_q == ST_PSDU)) &&
                        !buf_full_q && (bytes_left_q != 12'd0);
    assign byte_xfer  = Data_valid && data_ready;

    // The first bit of each byte comes straight from the buffer; the rest from the shifter.
    assign byte_start = (bit_cnt_q[2:0] == 3'd0);
    assign psdu_bit   = byte_start ? buf_q[0] : cur_q[0];
    assign scr_in     = (state_q == ST_PSDU) ? psdu_bit : 1'b0;

    assign signal_word = {rate_q, 1'b0, len_q, ^{rate_q, len_q}, 6'b000000};
    assign psdu_last   = {len_q, 3'b000} - 15'd1;
`ifdef TX_PAD_EN
    assign sym_last    = n_dbps(rate_q) - 8'd1;
`endif

    tx_scrambler #(
        .SEED(SCRAMBLER_SEED)
    ) u_scrambler (
        .clk    (Clock),
        .rst    (Reset),
        .load   (scr_load),
        .enable (scr_en),
        .bit_in (scr_in),
        .bit_out(scr_out)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rate_d       = rate_q;
        len_d        = len_q;
        bytes_left_d = bytes_left_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        cur_d        = cur_q;
        error_d      = error_q;
        done_d       = 1'b0;
        tx_bit       = 1'b0;
        tx_valid     = 1'b0;
        underrun     = 1'b0;
        scr_load     = 1'b0;
        scr_en       = 1'b0;
`ifdef TX_PAD_EN
        sym_d        = sym_q;
`endif

        if (byte_xfer) begin
            buf_d        = Data_in;
            buf_full_d   = 1'b1;
            bytes_left_d = bytes_left_q - 12'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if ((Length != 12'd0) && rate_is_valid(Rate)) begin
                        state_d      = ST_PREAMBLE;
                        bit_cnt_d    = 15'd0;
                        rate_d       = Rate;
                        len_d        = Length;
                        bytes_left_d = Length;
                        buf_full_d   = 1'b0;
                        error_d      = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                tx_valid = 1'b1;
                tx_bit   = PREAMBLE_BYTE[3'd7 - bit_cnt_q[2:0]];
                if (bit_cnt_q == 15'(PREAMBLE_BITS - 1)) begin
                    state_d   = ST_SIGNAL;
                    bit_cnt_d = 15'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
            ST_SIGNAL: begin
                tx_valid = 1'b1;
                tx_bit   = signal_word[5'd23 - bit_cnt_q[4:0]];
                if (bit_cnt_q == 15'(SIGNAL_BITS - 1)) begin
                    state_d   = ST_SERVICE;
                    bit_cnt_d = 15'd0;
                    scr_load  = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
            ST_SERVICE: begin
                tx_valid = 1'b1;
                tx_bit   = scr_out;
                scr_en   = 1'b1;
                if (bit_cnt_q == 15'(SERVICE_BITS - 1)) begin
                    state_d   = ST_PSDU;
                    bit_cnt_d = 15'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
            ST_PSDU: begin
                if (byte_start && !buf_full_q) begin
                    underrun = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tx_valid = 1'b1;
                    tx_bit   = scr_out;
                    scr_en   = 1'b1;
                    if (byte_start) begin
                        cur_d      = {1'b0, buf_q[7:1]};
                        buf_full_d = 1'b0;
                    end else begin
                        cur_d = {1'b0, cur_q[7:1]};
                    end
                    if (bit_cnt_q == psdu_last) begin
                        state_d   = ST_TAIL;
                        bit_cnt_d = 15'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 15'd1;
                    end
                end
            end
            ST_TAIL: begin
                // Tail bits flush the encoder, so they leave as zeros although the scrambler runs on.
                tx_valid = 1'b1;
                tx_bit   = 1'b0;
                scr_en   = 1'b1;
                if (bit_cnt_q == 15'(TAIL_BITS - 1)) begin
                    bit_cnt_d = 15'd0;
`ifdef TX_PAD_EN
                    if (sym_q == sym_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_PAD;
                    end
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
`ifdef TX_PAD_EN
            ST_PAD: begin
                tx_valid = 1'b1;
                tx_bit   = scr_out;
                scr_en   = 1'b1;
                if (sym_q == sym_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef TX_PAD_EN
        // Position within the OFDM symbol, counted from the first SERVICE bit.
        if (scr_load) begin
            sym_d = 8'd0;
        end else if (scr_en) begin
            sym_d = (sym_q == sym_last) ? 8'd0 : sym_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 15'd0;
            rate_q       <= 4'd0;
            len_q        <= 12'd0;
            bytes_left_q <= 12'd0;
            buf_q        <= 8'd0;
            buf_full_q   <= 1'b0;
            cur_q        <= 8'd0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
`ifdef TX_PAD_EN
            sym_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rate_q       <= rate_d;
            len_q        <= len_d;
            bytes_left_q <= bytes_left_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            cur_q        <= cur_d;
            error_q      <= error_d;
            done_q       <= done_d;
`ifdef TX_PAD_EN
            sym_q        <= sym_d;
`endif
        end
    end

    assign Data_ready = data_ready;
    assign Tx_bit     = tx_bit;
    assign Tx_valid   = tx_valid;
    assign Busy       = (state_q != ST_IDLE);
    assign Done       = done_q;
    assign Error      = error_q | underrun;

endmodule

// File: tb/tb_plcp_transmitter.sv
// Directed bench for plcp_transmitter: whole frames against a bit-level model plus
// hand-computed SIGNAL words, scrambler output, Done cycles, rejects, underrun and reset.
module tb_plcp_transmitter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  rate;
    logic [11:0] length;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic        tx_bit;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic       got_q[$];
    logic       exp_q[$];
    logic [7:0] data_mem[0:7];
    int         feed_idx;
    int         feed_limit;

    plcp_transmitter dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .Rate      (rate),
        .Length    (length),
        .Data_in   (data_in),
        .Data_valid(data_valid),
        .Data_ready(data_ready),
        .Tx_bit    (tx_bit),
        .Tx_valid  (tx_valid),
        .Busy      (busy),
        .Done      (done),
        .Error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        logic xfer;
        xfer = data_valid && data_ready;
        @(posedge clk);
        #1;
        if (xfer) begin
            feed_idx++;
            data_in    = data_mem[feed_idx % 8];
            data_valid = (feed_idx < feed_limit);
        end
    endtask

    function automatic int bench_ndbps(input logic [3:0] r);
        case (r)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            default: return 216;
        endcase
    endfunction

    // Reference frame: output sequence p[n] = p[n-7] ^ p[n-4], history seeded with ones.
    task automatic build_expected(input logic [3:0] r, input logic [11:0] len);
        logic [7:0]  pre;
        logic [23:0] sig;
        logic        pv[0:1023];
        logic        d[$];
        int          nbits;
        int          pad;
        int          ntail0;
        exp_q.delete();
        d.delete();
        pre = 8'hAA;
        for (int i = 0; i < 96; i++) exp_q.push_back(pre[7 - (i % 8)]);
        sig = {r, 1'b0, len, ^{r, len}, 6'b000000};
        for (int i = 23; i >= 0; i--) exp_q.push_back(sig[i]);
        for (int i = 0; i < 16; i++) d.push_back(1'b0);
        for (int b = 0; b < int'(len); b++)
            for (int k = 0; k < 8; k++) d.push_back(data_mem[b % 8][k]);
        ntail0 = d.size();
        for (int i = 0; i < 6; i++) d.push_back(1'b0);
        nbits = d.size();
`ifdef TX_PAD_EN
        pad = (bench_ndbps(r) - (nbits % bench_ndbps(r))) % bench_ndbps(r);
`else
        pad = 0;
`endif
        for (int i = 0; i < pad; i++) d.push_back(1'b0);
        for (int i = 0; i < 7; i++) pv[i] = 1'b1;
        for (int n = 0; n < d.size(); n++) begin
            pv[n + 7] = pv[n] ^ pv[n + 3];
            if (n >= ntail0 && n < ntail0 + 6) exp_q.push_back(1'b0);
            else exp_q.push_back(d[n] ^ pv[n + 7]);
        end
    endtask

    // Starts a frame and collects bits until Done or the cycle budget runs out.
    task automatic run_frame(input logic [3:0] r, input logic [11:0] len, input int n_supply,
                             input int poke_cycle, output int done_cycle, output int err_seen,
                             output int bad_ready, output int busy_at_done);
        int cyc;
        rate       = r;
        length     = len;
        start      = 1'b1;
        feed_idx   = 0;
        feed_limit = n_supply;
        data_in    = data_mem[0];
        data_valid = (n_supply > 0);
        step();
        start        = 1'b0;
        got_q.delete();
        done_cycle   = -1;
        err_seen     = 0;
        bad_ready    = 0;
        busy_at_done = -1;
        cyc          = 1;
        while (cyc <= 400 && done_cycle < 0) begin
            if (tx_valid) got_q.push_back(tx_bit);
            if (error) err_seen++;
            if (data_ready && cyc <= 120) bad_ready++;
            if (done) begin
                done_cycle   = cyc;
                busy_at_done = int'(busy);
            end
            if (cyc == poke_cycle) begin
                start  = 1'b1;
                length = 12'd0;
                rate   = 4'b0000;
            end else begin
                start = 1'b0;
            end
            if (done_cycle < 0) begin
                step();
                cyc++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] r, input logic [11:0] len,
                               input int done_exp, input int done_cycle, input int err_seen,
                               input int bad_ready, input int busy_at_done);
        int mism;
        int first;
        build_expected(r, len);
        check({tag, "_bits"}, got_q.size(), exp_q.size());
        mism  = 0;
        first = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_mismatch_count"}, mism, 0);
        if (mism != 0) $display("  first differing bit index %0d", first);
        check({tag, "_done_cycle"}, done_cycle, done_exp);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_error_during"}, err_seen, 0);
        check({tag, "_early_ready"}, bad_ready, 0);
    endtask

    initial begin
        int          dc;
        int          es;
        int          br;
        int          bd;
        int          dn;
        logic [23:0] w;

        rst        = 1'b1;
        start      = 1'b0;
        rate       = 4'b0000;
        length     = 12'd0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        feed_idx   = 0;
        feed_limit = 0;
        for (int i = 0; i < 8; i++) data_mem[i] = 8'h00;
        step();
        step();
        check("reset_busy", busy, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_bit", tx_bit, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_data_ready", data_ready, 0);
        rst = 1'b0;
        step();

        // Frame A: 6 Mb/s, one zero byte.
        data_mem[0] = 8'h00;
        run_frame(4'b1101, 12'd1, 1, -1, dc, es, br, bd);
`ifdef TX_PAD_EN
        check_frame("frame_a", 4'b1101, 12'd1, 169, dc, es, br, bd);
`else
        check_frame("frame_a", 4'b1101, 12'd1, 151, dc, es, br, bd);
`endif
        for (int i = 0; i < 24; i++) w[23 - i] = got_q[96 + i];
        check("frame_a_signal", w, 24'b1101_0_000000000001_0_000000);
        for (int i = 0; i < 24; i++) w[23 - i] = got_q[120 + i];
        check("frame_a_scrambled", w, 24'b00001110_11110010_11001001);
        step();
        check("frame_a_done_pulse_width", done, 0);

        // Frame B: 36 Mb/s, three bytes, odd SIGNAL parity.
        data_mem[0] = 8'hA5;
        data_mem[1] = 8'h3C;
        data_mem[2] = 8'hF0;
        run_frame(4'b1011, 12'd3, 3, -1, dc, es, br, bd);
`ifdef TX_PAD_EN
        check_frame("frame_b", 4'b1011, 12'd3, 265, dc, es, br, bd);
`else
        check_frame("frame_b", 4'b1011, 12'd3, 167, dc, es, br, bd);
`endif
        for (int i = 0; i < 24; i++) w[23 - i] = got_q[96 + i];
        check("frame_b_signal", w, 24'b1011_0_000000000011_1_000000);
        step();

        // Rejects: zero length, then an illegal rate code after a reset.
        check("pre_reject_error", error, 0);
        rate   = 4'b1101;
        length = 12'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("reject_len0_error", error, 1);
        check("reject_len0_busy", busy, 0);
        step();
        check("reject_len0_sticky", error, 1);
        check("reject_len0_tx_valid", tx_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_clears_error", error, 0);
        rate   = 4'b0000;
        length = 12'd5;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("reject_rate_error", error, 1);
        check("reject_rate_busy", busy, 0);

        // Frame C: 54 Mb/s; an invalid Start mid-frame must be ignored, and the accept clears Error.
        data_mem[0] = 8'h5A;
        data_mem[1] = 8'hC3;
        run_frame(4'b0011, 12'd2, 2, 60, dc, es, br, bd);
`ifdef TX_PAD_EN
        check_frame("frame_c", 4'b0011, 12'd2, 337, dc, es, br, bd);
`else
        check_frame("frame_c", 4'b0011, 12'd2, 159, dc, es, br, bd);
`endif
        step();

        // Underrun: Length=2 with only the first byte supplied.
        data_mem[0] = 8'h81;
        rate       = 4'b0101;
        length     = 12'd2;
        start      = 1'b1;
        feed_idx   = 0;
        feed_limit = 1;
        data_in    = data_mem[0];
        data_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (143) step();
        check("underrun_before_error", error, 0);
        check("underrun_before_tx_valid", tx_valid, 1);
        step();
        check("underrun_error", error, 1);
        check("underrun_tx_valid", tx_valid, 0);
        check("underrun_busy_same_cycle", busy, 1);
        step();
        check("underrun_idle_busy", busy, 0);
        check("underrun_error_sticky", error, 1);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dn++;
            step();
        end
        check("underrun_no_done", dn, 0);

        // Reset in the middle of PSDU, then a normal frame.
        data_mem[0] = 8'h12;
        data_mem[1] = 8'h34;
        rate       = 4'b0111;
        length     = 12'd2;
        start      = 1'b1;
        feed_idx   = 0;
        feed_limit = 2;
        data_in    = data_mem[0];
        data_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (139) step();
        check("mid_psdu_busy", busy, 1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        data_valid = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_tx_valid", tx_valid, 0);
        check("mid_reset_error", error, 0);
        data_mem[0] = 8'h00;
        run_frame(4'b1101, 12'd1, 1, -1, dc, es, br, bd);
`ifdef TX_PAD_EN
        check_frame("after_reset", 4'b1101, 12'd1, 169, dc, es, br, bd);
`else
        check_frame("after_reset", 4'b1101, 12'd1, 151, dc, es, br, bd);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
